cp0_intr_ctrl: RTL and testbench
================================

// Module: cp0_intr_ctrl
// PURPOSE
//  Coprocessor-0 interrupt controller: Count, Compare, Status, Cause and EPC registers.
//  Sits upstream of the ISR instruction ROM. Latches hardware interrupt sources into Cause.IP.
//  Decides when the pipeline takes an interrupt, saves the interrupted PC in EPC,
//  and redirects fetch to the ISR base. Serves the mfc0/mtc0 accesses the ISR uses.
// PARAMETERS
//  ISR_BASE  32'h0000_0000 (default)  fetch address driven on handler_pc when an interrupt is taken
// PORTS
//  clk         in   1   system clock; every register samples on the rising edge
//  rst         in   1   synchronous, active-high reset
//  cp0_we      in   1   mtc0 strobe: write cp0_wdata into register cp0_waddr this cycle
//  cp0_waddr   in   5   mtc0 target register number (9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC)
//  cp0_wdata   in   32  mtc0 data
//  cp0_raddr   in   5   mfc0 source register number
//  cp0_rdata   out  32  mfc0 data; combinational from cp0_raddr; 0 for unimplemented registers
//  uart_rx_vld in   1   UART receive data valid (level)
//  uart_tx_rdy in   1   UART transmitter ready (level)
//  ext_int     in   1   external/button interrupt (level)
//  int_ok      in   1   pipeline may be interrupted now (not stalled, not in a delay slot)
//  cur_pc      in   32  PC of the oldest uncommitted instruction; this PC is re-executed on return
//  irq_take    out  1   one-cycle pulse: flush the pipeline and fetch from handler_pc
//  handler_pc  out  32  constant ISR_BASE
// BEHAVIOUR
//  Reset:
//   - Count=0, Compare=32'hFFFF_FFFF, Status=0 (IE=0, IM=0), Cause=0, EPC=0.
//   - Edge-detect history registers = 0.
//   - irq_take=0.
//  Count:
//   - Increments by 1 every cycle and wraps 32'hFFFF_FFFF -> 0.
//   - mtc0 to reg 9 loads cp0_wdata in place of the increment.
//  Status:
//   - Bit 0 is IE; bits 15:10 are IM[7:2].
//   - All other bits are writable storage with no effect.
//  Cause:
//   - Only bits 15:10 (IP[7:2]) are implemented; all other bits read 0.
//   - IP bits are sticky. Hardware sets them; software clears them via mtc0 (read-modify-write).
//   - IP7 (bit 15): set in the cycle after Count == Compare.
//   - IP6 (bit 14): set on a rising edge of ext_int.
//   - IP3 (bit 11): set on a rising edge of uart_tx_rdy.
//   - IP2 (bit 10): set on a rising edge of uart_rx_vld.
//   - IP5 and IP4 are software-writable only.
//   - Edge detection uses a 1-cycle registered copy of each input.
//   - If a hardware set and an mtc0 write to Cause land in the same cycle, the set wins for that bit.
//  Take condition:
//   - pend = Status.IE & |(Cause[15:10] & Status[15:10]) & int_ok & ~irq_take_q.
//   - pend is evaluated on the current (already-registered) register values.
//   - irq_take = pend, combinational, held high for exactly one cycle.
//  On the clock edge where irq_take=1:
//   - EPC <= cur_pc.
//   - Status.IE <= 0, overriding any simultaneous mtc0 to Status.
//   - Cause is unchanged.
//  No two takes on consecutive cycles: irq_take_q (the registered irq_take) suppresses back-to-back takes.
//  Return:
//   - No hardware eret. The ISR tail reads EPC, sets Status.IE with mtc0, and jumps.
//   - IE becomes 1 on the edge of that mtc0. A pending source can be taken from the next cycle.
//  mtc0 to reg 14 writes EPC directly. Writes to unimplemented registers are ignored.
//  rst mid-operation: all state returns to reset values on the next edge. A take in that cycle is discarded.
// TESTING
//  1. Reset, then write Compare=20, Status=32'h8001.
//     -> irq_take pulses exactly when Count=22.
//     -> EPC = cur_pc of that cycle; Cause=32'h8000; Status.IE=0.
//  2. Hold uart_rx_vld=1 for 10 cycles with Status=32'h0401.
//     -> a single irq_take; Cause[10]=1.
//     -> mtc0 Cause=0 while still high -> no re-trigger until the next rising edge.
//  3. Status=32'h0800 (IE=0), pulse uart_tx_rdy -> Cause[11]=1 and no take.
//     -> mtc0 Status=32'h0801 -> irq_take on the following cycle.
//  4. Same-cycle ext_int rising edge and mtc0 Cause=0 -> Cause[14]=1 afterwards.
//  5. Pending, enabled source with int_ok=0 for 5 cycles -> no take.
//     -> take in the first cycle int_ok=1, with EPC = cur_pc of that cycle.
//  6. Count written to 32'hFFFF_FFFE -> reads 32'hFFFF_FFFF, then 0.
//     -> rst asserted on a take cycle -> EPC=0 and IE=0 after the edge.

Source files
------------

// File: rtl/cp0_intr_ctrl_if.sv
// Bundles the CP0 mfc0/mtc0 bus, the interrupt source levels and the pipeline
// take/redirect signals that connect the controller to the core.
interface cp0_intr_ctrl_if;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic [4:0]  cp0_raddr;
  logic [31:0] cp0_rdata;
  logic        uart_rx_vld;
  logic        uart_tx_rdy;
  logic        ext_int;
  logic        int_ok;
  logic [31:0] cur_pc;
  logic        irq_take;
  logic [31:0] handler_pc;

  modport master (
    output cp0_we, cp0_waddr, cp0_wdata, cp0_raddr,
    output uart_rx_vld, uart_tx_rdy, ext_int, int_ok, cur_pc,
    input  cp0_rdata, irq_take, handler_pc
  );

  modport slave (
    input  cp0_we, cp0_waddr, cp0_wdata, cp0_raddr,
    input  uart_rx_vld, uart_tx_rdy, ext_int, int_ok, cur_pc,
    output cp0_rdata, irq_take, handler_pc
  );
endinterface

// File: rtl/cp0_intr_ctrl.sv
// Coprocessor-0 interrupt controller: Count/Compare timer, Status, Cause, EPC,
// interrupt take decision and fetch redirect to the ISR base.
module cp0_intr_ctrl #(
  parameter logic [31:0] ISR_BASE = 32'h0000_0000
) (
  input logic            clk,
  input logic            rst,
  cp0_intr_ctrl_if.slave bus
);
  localparam int DATA_W = 32;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  logic [DATA_W-1:0] count;
  logic [DATA_W-1:0] compare;
  logic [DATA_W-1:0] status;
  logic [DATA_W-1:0] epc;
  logic [5:0]        cause_ip;

  logic rx_vld_p1;
  logic tx_rdy_p1;
  logic ext_int_p1;
  logic cmp_hit_p1;
  logic irq_take_p1;

  logic we_count;
  logic we_compare;
  logic we_status;
  logic we_cause;
  logic we_epc;

  logic [5:0]        hw_set;
  logic              take;
  logic [DATA_W-1:0] rdata;

  function automatic logic rise(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

  always_comb begin
    we_count   = bus.cp0_we && (bus.cp0_waddr == REG_COUNT);
    we_compare = bus.cp0_we && (bus.cp0_waddr == REG_COMPARE);
    we_status  = bus.cp0_we && (bus.cp0_waddr == REG_STATUS);
    we_cause   = bus.cp0_we && (bus.cp0_waddr == REG_CAUSE);
    we_epc     = bus.cp0_we && (bus.cp0_waddr == REG_EPC);
  end

  // Hardware set vector for IP[7:2]; IP5/IP4 have no hardware source.
  always_comb begin
    hw_set    = '0;
    hw_set[5] = cmp_hit_p1;
    hw_set[4] = rise(bus.ext_int, ext_int_p1);
    hw_set[1] = rise(bus.uart_tx_rdy, tx_rdy_p1);
    hw_set[0] = rise(bus.uart_rx_vld, rx_vld_p1);
  end

  always_comb begin
    take = status[0] & (|(cause_ip & status[15:10])) & bus.int_ok & ~irq_take_p1;
  end

  // ---- stage p1: one-cycle history for edge detect, timer match and take ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_vld_p1   <= 1'b0;
      tx_rdy_p1   <= 1'b0;
      ext_int_p1  <= 1'b0;
      cmp_hit_p1  <= 1'b0;
      irq_take_p1 <= 1'b0;
    end else begin
      rx_vld_p1   <= bus.uart_rx_vld;
      tx_rdy_p1   <= bus.uart_tx_rdy;
      ext_int_p1  <= bus.ext_int;
      cmp_hit_p1  <= (count == compare);
      irq_take_p1 <= take;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (we_count) begin
      count <= bus.cp0_wdata;
    end else begin
      count <= count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      compare <= '1;
    end else if (we_compare) begin
      compare <= bus.cp0_wdata;
    end
  end

  // A take clears IE even when software writes Status in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      status <= '0;
    end else begin
      if (we_status) begin
        status <= bus.cp0_wdata;
      end
      if (take) begin
        status[0] <= 1'b0;
      end
    end
  end

  // Hardware sets are OR-ed after the software write so a same-cycle set wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      cause_ip <= '0;
    end else begin
      cause_ip <= (we_cause ? bus.cp0_wdata[15:10] : cause_ip) | hw_set;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      epc <= '0;
    end else if (take) begin
      epc <= bus.cur_pc;
    end else if (we_epc) begin
      epc <= bus.cp0_wdata;
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.cp0_raddr)
      REG_COUNT:   rdata = count;
      REG_COMPARE: rdata = compare;
      REG_STATUS:  rdata = status;
      REG_CAUSE:   rdata = {16'h0000, cause_ip, 10'b0};
      REG_EPC:     rdata = epc;
      default:     rdata = '0;
    endcase
  end

  assign bus.cp0_rdata  = rdata;
  assign bus.irq_take   = take;
  assign bus.handler_pc = ISR_BASE;

endmodule

// File: tb/tb_cp0_intr_ctrl.sv
// Scoreboard bench for cp0_intr_ctrl: stimulus queues expected values tagged
// with the cycle they apply to; a negedge monitor pops and compares them.
module tb_cp0_intr_ctrl;
  localparam logic [31:0] ISR  = 32'h0000_0180;
  localparam logic [31:0] IDLE = 32'hDEAD_BEEF;
  localparam int K_RD  = 0;
  localparam int K_IRQ = 1;
  localparam int K_HPC = 2;

  typedef struct {
    int               cyc;
    int               kind;
    logic [31:0]      exp;
    logic [8*16-1:0]  name;
  } chk_t;

  chk_t sb[$];
  logic clk = 1'b0;
  logic rst;
  int   cyc     = 0;
  int   n_pass  = 0;
  int   n_total = 0;

  cp0_intr_ctrl_if bus();

  cp0_intr_ctrl #(.ISR_BASE(ISR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every expectation registered for the current cycle.
  always @(negedge clk) begin
    chk_t        c;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      c = sb.pop_front();
      case (c.kind)
        K_RD:    act = bus.cp0_rdata;
        K_IRQ:   act = {31'b0, bus.irq_take};
        default: act = bus.handler_pc;
      endcase
      n_total++;
      if (c.cyc != cyc)
        $display("FAIL %0s: expectation for cycle %0d sampled late in cycle %0d", c.name, c.cyc, cyc);
      else if (act === c.exp)
        n_pass++;
      else
        $display("FAIL %0s: actual %h required %h (cycle %0d)", c.name, act, c.exp, cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    bus.cp0_we = 1'b0;
  endtask

  task automatic push(input int kind, input logic [31:0] exp, input logic [8*16-1:0] name);
    chk_t c;
    c.cyc  = cyc;
    c.kind = kind;
    c.exp  = exp;
    c.name = name;
    sb.push_back(c);
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] e, input logic [8*16-1:0] n);
    bus.cp0_raddr = a;
    push(K_RD, e, n);
  endtask

  task automatic irq(input logic e, input logic [8*16-1:0] n);
    push(K_IRQ, {31'b0, e}, n);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.cp0_we    = 1'b1;
    bus.cp0_waddr = a;
    bus.cp0_wdata = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks pending", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $finish;
  end

  initial begin
    rst = 1'b1;
    bus.cp0_we = 1'b0; bus.cp0_waddr = '0; bus.cp0_wdata = '0; bus.cp0_raddr = '0;
    bus.uart_rx_vld = 1'b0; bus.uart_tx_rdy = 1'b0; bus.ext_int = 1'b0;
    bus.int_ok = 1'b1; bus.cur_pc = IDLE;
    step(); step();
    rst = 1'b0;

    // Reset values, register masking and unimplemented registers.
    rd(5'd9, 32'h0, "rst_count"); irq(1'b0, "rst_irq"); push(K_HPC, ISR, "handler_pc"); step();
    rd(5'd11, 32'hFFFF_FFFF, "rst_compare"); step();
    rd(5'd12, 32'h0, "rst_status"); step();
    rd(5'd13, 32'h0, "rst_cause"); step();
    rd(5'd14, 32'h0, "rst_epc"); step();
    rd(5'd9, 32'd5, "count_run"); wr(5'd13, 32'hFFFF_FFFF); step();
    rd(5'd13, 32'h0000_FC00, "cause_mask"); wr(5'd8, 32'h1234_5678); step();
    rd(5'd8, 32'h0, "unimpl_rd"); irq(1'b0, "no_take_ie0"); step();

    // Timer interrupt: Compare=20 fires when Count=22.
    rst = 1'b1; step(); rst = 1'b0;
    wr(5'd11, 32'd20); step();
    wr(5'd12, 32'h0000_8001); step();
    for (int k = 2; k <= 21; k++) begin
      irq(1'b0, "t1_early"); rd(5'd9, k, "t1_count"); step();
    end
    bus.cur_pc = 32'h0040_0120; irq(1'b1, "t1_take"); rd(5'd9, 32'd22, "t1_take_count"); step();
    bus.cur_pc = IDLE; irq(1'b0, "t1_pulse"); rd(5'd14, 32'h0040_0120, "t1_epc"); step();
    rd(5'd13, 32'h0000_8000, "t1_cause"); step();
    rd(5'd12, 32'h0000_8000, "t1_status"); step();

    // UART rx held level: one take, software clear, retrigger on next edge.
    wr(5'd13, 32'h0); step();
    wr(5'd12, 32'h0000_0401); step();
    bus.uart_rx_vld = 1'b1; irq(1'b0, "t2_pre"); step();
    bus.cur_pc = 32'h0040_0200; irq(1'b1, "t2_take"); step();
    bus.cur_pc = IDLE; irq(1'b0, "t2_single"); rd(5'd13, 32'h0000_0400, "t2_cause"); step();
    wr(5'd13, 32'h0); irq(1'b0, "t2_single"); step();
    wr(5'd12, 32'h0000_0401); irq(1'b0, "t2_single"); rd(5'd14, 32'h0040_0200, "t2_epc"); step();
    for (int k = 0; k < 5; k++) begin
      irq(1'b0, "t2_held"); rd(5'd13, 32'h0, "t2_nocause"); step();
    end
    bus.uart_rx_vld = 1'b0; step();
    bus.uart_rx_vld = 1'b1; irq(1'b0, "t2_edge"); step();
    irq(1'b1, "t2_retrig"); step();
    bus.uart_rx_vld = 1'b0; wr(5'd13, 32'h0); irq(1'b0, "t2_after"); step();

    // UART tx pulse while IE=0, then enable.
    wr(5'd12, 32'h0000_0800); step();
    bus.uart_tx_rdy = 1'b1; step();
    bus.uart_tx_rdy = 1'b0; irq(1'b0, "t3_noie"); step();
    rd(5'd13, 32'h0000_0800, "t3_cause"); irq(1'b0, "t3_noie"); step();
    wr(5'd12, 32'h0000_0801); irq(1'b0, "t3_noie"); step();
    bus.cur_pc = 32'h0040_0300; irq(1'b1, "t3_take"); step();
    bus.cur_pc = IDLE; irq(1'b0, "t3_after"); rd(5'd12, 32'h0000_0800, "t3_ie_clr"); step();

    // Hardware set beats a same-cycle software clear.
    bus.ext_int = 1'b1; wr(5'd13, 32'h0); step();
    rd(5'd13, 32'h0000_4000, "t4_set_wins"); step();

    // int_ok gating; take-edge IE clear beats a same-cycle mtc0 to Status.
    bus.ext_int = 1'b0; bus.int_ok = 1'b0; wr(5'd12, 32'h0000_4001); step();
    for (int k = 0; k < 5; k++) begin
      irq(1'b0, "t5_blocked"); step();
    end
    bus.int_ok = 1'b1; bus.cur_pc = 32'h0040_0500; wr(5'd12, 32'h0000_4001);
    irq(1'b1, "t5_take"); step();
    bus.cur_pc = IDLE; rd(5'd14, 32'h0040_0500, "t5_epc"); irq(1'b0, "t5_after"); step();
    rd(5'd12, 32'h0000_4000, "t5_ie_ovr"); step();

    // Count wrap, then reset on a take cycle.
    wr(5'd9, 32'hFFFF_FFFE); step();
    rd(5'd9, 32'hFFFF_FFFE, "t6_cnt_load"); step();
    rd(5'd9, 32'hFFFF_FFFF, "t6_cnt_max"); step();
    rd(5'd9, 32'h0, "t6_wrap"); step();
    wr(5'd12, 32'h0000_4001); step();
    rst = 1'b1; bus.cur_pc = 32'h0040_0600; step();
    rst = 1'b0; bus.cur_pc = IDLE; rd(5'd14, 32'h0, "t6_rst_epc"); irq(1'b0, "t6_rst_irq"); step();
    rd(5'd12, 32'h0, "t6_rst_ie"); step();
    rd(5'd9, 32'd2, "t6_rst_cnt"); step();
    step(); step();

    while (sb.size() > 0) begin
      chk_t c;
      c = sb.pop_front();
      n_total++;
      $display("FAIL %0s: expectation never sampled (cycle %0d)", c.name, c.cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
